inertial_fusion_integrator: RTL and testbench

//  Multi-channel complementary filter: per channel, integrates offset-corrected gyro rate and nudges
//  the integral toward an accel-derived angle by a fixed step per sample. Generalises the single-axis

---
 rtl/inertial_fusion_integrator.sv | 179 +++++++++++++++++
 tb/tb_inertial_fusion_integrator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inertial_fusion_integrator.sv
// Multi-channel complementary filter: offset-corrected gyro integration
// nudged toward an accel-derived angle, with on-chip offset calibration.
module inertial_fusion_integrator #(
    parameter int NUM_CH      = 2,
    parameter int DW          = 16,
    parameter int ACC_W       = 27,
    parameter int FUSION_STEP = 1024,
    parameter int ACC_GAIN    = 327,
    parameter int ACC_SH      = 13,
    parameter int CAL_LOG2    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld,
    input  logic [NUM_CH*DW-1:0] rate,
    input  logic [NUM_CH*DW-1:0] accel,
    input  logic                 cal_req,
    output logic [NUM_CH*DW-1:0] angle,
    output logic                 rdy,
    output logic                 cal_busy,
    output logic [NUM_CH-1:0]    sat
);

    localparam int SW = DW + CAL_LOG2;
    localparam int CW = CAL_LOG2 + 1;
    localparam int PW = DW + 32;
    localparam int IW = ACC_W + 2;

    localparam logic [CW-1:0] CAL_LAST = CW'((1 << CAL_LOG2) - 1);
    localparam logic signed [IW-1:0] I_MAX =
        {{3{1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [IW-1:0] I_MIN =
        {{3{1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [IW-1:0] FSTEP = IW'(FUSION_STEP);
    localparam logic signed [PW-1:0] GAIN = PW'(ACC_GAIN);

    typedef enum logic {
        S_CAL,
        S_RUN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic          cal_step;
    logic          cal_done;
    logic          run_step;

    logic signed [SW-1:0]    rate_sum [NUM_CH];
    logic signed [SW-1:0]    acc_sum  [NUM_CH];
    logic signed [DW-1:0]    rate_off [NUM_CH];
    logic signed [DW-1:0]    acc_off  [NUM_CH];
    logic signed [ACC_W-1:0] integ    [NUM_CH];

    logic signed [SW-1:0]    rs_nxt   [NUM_CH];
    logic signed [SW-1:0]    as_nxt   [NUM_CH];
    logic signed [DW-1:0]    rc       [NUM_CH];
    logic signed [DW-1:0]    ac       [NUM_CH];
    logic signed [PW-1:0]    prod     [NUM_CH];
    logic signed [DW-1:0]    acc_ang  [NUM_CH];
    logic signed [DW-1:0]    cur      [NUM_CH];
    logic signed [IW-1:0]    f        [NUM_CH];
    logic signed [IW-1:0]    wide     [NUM_CH];
    logic signed [ACC_W-1:0] integ_nxt[NUM_CH];
    logic [NUM_CH-1:0]       clip;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_CAL;
        else        state <= state_nxt;
    end

    // Next-state and step qualifiers; recalibration request overrides all
    always_comb begin
        state_nxt = state;
        cal_step  = 1'b0;
        cal_done  = 1'b0;
        run_step  = 1'b0;
        if (cal_req) begin
            state_nxt = S_CAL;
        end else begin
            unique case (state)
                S_CAL: begin
                    cal_step = vld;
                    if (vld && cnt == CAL_LAST) begin
                        cal_done  = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: run_step = vld;
                default: state_nxt = S_CAL;
            endcase
        end
    end

    // Per-channel calibration sums and fusion/integration arithmetic
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            rs_nxt[k] = rate_sum[k] +
                {{CAL_LOG2{rate[k*DW+DW-1]}}, rate[k*DW +: DW]};
            as_nxt[k] = acc_sum[k] +
                {{CAL_LOG2{accel[k*DW+DW-1]}}, accel[k*DW +: DW]};
            rc[k] = rate[k*DW +: DW] - rate_off[k];
            ac[k] = accel[k*DW +: DW] - acc_off[k];
            prod[k] = {{(PW-DW){ac[k][DW-1]}}, ac[k]} * GAIN;
            acc_ang[k] = DW'(prod[k] >>> ACC_SH);
            cur[k] = integ[k][ACC_W-1 -: DW];
            f[k] = (acc_ang[k] > cur[k]) ? FSTEP : -FSTEP;
            wide[k] = {{2{integ[k][ACC_W-1]}}, integ[k]}
                    - {{(IW-DW){rc[k][DW-1]}}, rc[k]}
                    + f[k];
            clip[k] = 1'b0;
            integ_nxt[k] = wide[k][ACC_W-1:0];
            if (wide[k] > I_MAX) begin
                integ_nxt[k] = I_MAX[ACC_W-1:0];
                clip[k] = 1'b1;
            end else if (wide[k] < I_MIN) begin
                integ_nxt[k] = I_MIN[ACC_W-1:0];
                clip[k] = 1'b1;
            end
        end
    end

    // Calibration counter, sums and offsets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                rate_sum[k] <= '0;
                acc_sum[k]  <= '0;
                rate_off[k] <= '0;
                acc_off[k]  <= '0;
            end
        end else if (cal_req || cal_done) begin
            cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                rate_sum[k] <= '0;
                acc_sum[k]  <= '0;
                if (cal_done) begin
                    rate_off[k] <= DW'(rs_nxt[k] >>> CAL_LOG2);
                    acc_off[k]  <= DW'(as_nxt[k] >>> CAL_LOG2);
                end
            end
        end else if (cal_step) begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                rate_sum[k] <= rs_nxt[k];
                acc_sum[k]  <= as_nxt[k];
            end
        end
    end

    // Integrators and sticky saturation flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= '0;
            for (int k = 0; k < NUM_CH; k++) integ[k] <= '0;
        end else if (cal_req) begin
            sat <= '0;
            for (int k = 0; k < NUM_CH; k++) integ[k] <= '0;
        end else if (run_step) begin
            sat <= sat | clip;
            for (int k = 0; k < NUM_CH; k++) integ[k] <= integ_nxt[k];
        end
    end

    // Update pulse aligned with the refreshed angle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy <= 1'b0;
        else        rdy <= run_step;
    end

    assign cal_busy = (state == S_CAL);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ang
        assign angle[k*DW +: DW] = integ[k][ACC_W-1 -: DW];
    end

endmodule

// File: tb/tb_inertial_fusion_integrator.sv
// Directed bench for inertial_fusion_integrator.
// Expected values are hand-derived from the filter equations.
module tb_inertial_fusion_integrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [31:0] rate;
    logic [31:0] accel;
    logic        cal_req;
    logic [31:0] angle;
    logic        rdy;
    logic        cal_busy;
    logic [1:0]  sat;

    int n_run  = 0;
    int n_fail = 0;
    int rdy_cnt = 0;
    int rdy_mark;

    inertial_fusion_integrator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .rate     (rate),
        .accel    (accel),
        .cal_req  (cal_req),
        .angle    (angle),
        .rdy      (rdy),
        .cal_busy (cal_busy),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rdy) rdy_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int n);
        @(negedge clk) vld = 1'b1;
        repeat (n) @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic calib();
        rate  = 32'h03C2_03C2;
        accel = 32'hFE80_FE80;
        send(16);
    endtask

    task automatic recal();
        @(negedge clk) cal_req = 1'b1;
        @(negedge clk) cal_req = 1'b0;
        calib();
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; cal_req = 1'b0;
        rate = '0; accel = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(cal_busy), 32'd1);
        chk("rst_angle", angle, 32'h0);
        chk("rst_sat", 32'(sat), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h0);
        rst_n = 1'b1;

        // calibration
        rate  = 32'h03C2_03C2;
        accel = 32'hFE80_FE80;
        send(15);
        chk("cal15_busy", 32'(cal_busy), 32'd1);
        send(1);
        chk("cal16_busy", 32'(cal_busy), 32'd0);
        chk("cal_angle", angle, 32'h0);
        @(negedge clk);
        chk("cal_no_rdy", 32'(rdy_cnt), 32'd0);

        // ch0 rc=-2048, ch1 idle
        rate = 32'h03C2_FBC2;
        send(8);
        chk("rc_angle0", 32'(angle[15:0]), 32'd4);
        chk("rc_angle1", 32'(angle[31:16]), 32'd0);
        chk("rc_rdy_hi", 32'(rdy), 32'd1);
        @(negedge clk);
        chk("rc_rdy_lo", 32'(rdy), 32'd0);
        chk("rc_rdy_cnt", 32'(rdy_cnt), 32'd8);

        // ch1 ac=+1000 -> acc_ang 39; ch0 idle
        recal();
        rate  = 32'h03C2_03C2;
        accel = 32'h0268_FE80;
        send(80);
        chk("acc80_a1", 32'(angle[31:16]), 32'd39);
        chk("acc80_a0", 32'(angle[15:0]), 32'h0);
        send(1);
        chk("acc81_a1", 32'(angle[31:16]), 32'd38);
        chk("idle81_a0", 32'(angle[15:0]), 32'hFFFF);
        send(1);
        chk("acc82_a1", 32'(angle[31:16]), 32'd39);
        chk("acc_sat", 32'(sat), 32'h0);

        // ch0 rc=-32768 -> positive saturation
        recal();
        rate  = 32'h03C2_83C2;
        accel = 32'hFE80_FE80;
        send(2114);
        chk("pre_sat", 32'(sat), 32'h0);
        chk("pre_sat_a0", 32'(angle[15:0]), 32'h7FFF);
        send(1);
        chk("sat_flag", 32'(sat), 32'h1);
        chk("sat_a0", 32'(angle[15:0]), 32'h7FFF);
        send(20);
        chk("sat_hold", 32'(angle[15:0]), 32'h7FFF);
        chk("sat_sticky", 32'(sat), 32'h1);
        chk("sat_a1", 32'(angle[31:16]), 32'hFFFF);

        // cal_req with simultaneous vld
        @(negedge clk) begin vld = 1'b1; cal_req = 1'b1; end
        @(negedge clk) begin vld = 1'b0; cal_req = 1'b0; end
        chk("creq_angle", angle, 32'h0);
        chk("creq_sat", 32'(sat), 32'h0);
        chk("creq_busy", 32'(cal_busy), 32'd1);
        chk("creq_rdy", 32'(rdy), 32'd0);

        // recalibrate with averages 16.5 -> 16 and -1.5 -> -2
        rdy_mark = rdy_cnt;
        for (int i = 0; i < 16; i++) begin
            rate  = {16'h03C2, (i % 2 == 0) ? 16'h0011 : 16'h0010};
            accel = {16'hFE80, (i % 2 == 0) ? 16'hFFFF : 16'hFFFE};
            send(1);
        end
        chk("recal_busy", 32'(cal_busy), 32'd0);
        @(negedge clk);
        chk("recal_no_rdy", 32'(rdy_cnt - rdy_mark), 32'd0);
        rate  = 32'h03C2_0010;
        accel = 32'hFE80_FFFE;
        send(1);
        chk("floor_a0_1", 32'(angle[15:0]), 32'hFFFF);
        send(1);
        chk("floor_a0_2", 32'(angle[15:0]), 32'h0);

        // asynchronous reset mid-run
        rate = 32'h03C2_FBC2;
        send(6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_angle", angle, 32'h0);
        chk("arst_busy", 32'(cal_busy), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        calib();
        chk("arst_recal", 32'(cal_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
